// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between NUM_REQ byte producers.
// Define UART_ARB_LOCK_EN to hold the link for the owner until the last byte of its message.
module uart_tx_arbiter_lane #(
  parameter int IDX_W = 2,
  parameter int LANE  = 0
) (
  input  logic             req,
  input  logic             lock,
  input  logic [IDX_W-1:0] owner,
  output logic             elig
);
  assign elig = req & (~lock | (owner == IDX_W'(LANE)));
endmodule

module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0][7:0] req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      gnt,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_busy,
  output logic                    arb_busy,
  output logic [IDX_W-1:0]        owner,
  output logic                    timeout_err
);
`ifdef UART_ARB_LOCK_EN
  localparam logic LOCK_EN = 1'b1;
`else
  localparam logic LOCK_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] elig, gnt_d;
  logic [IDX_W-1:0]   rr_q, rr_d, owner_d, hit;
  logic [IDX_W:0]     cand;
  logic               found, lock_q, lock_d, last_q, last_d, start_d, terr_d;
  logic [7:0]         data_d;
  logic [15:0]        timer_q, timer_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    uart_tx_arbiter_lane #(.IDX_W(IDX_W), .LANE(i)) u_lane (
      .req  (req[i]),
      .lock (lock_q),
      .owner(owner),
      .elig (elig[i])
    );
  end

  // Scan from the pointer upward, wrapping at NUM_REQ rather than 2**IDX_W.
  always_comb begin
    found = 1'b0;
    hit   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!found && elig[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        hit   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    start_d = 1'b0;
    terr_d  = 1'b0;
    data_d  = tx_data;
    owner_d = owner;
    rr_d    = rr_q;
    lock_d  = lock_q;
    last_d  = last_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        // A locked owner that withdraws gives up the link; no grant this cycle.
        if (lock_q && !req[owner]) lock_d = 1'b0;
        else if (found) begin
          gnt_d[hit] = 1'b1;
          start_d    = 1'b1;
          data_d     = req_data[hit];
          owner_d    = hit;
          rr_d       = (hit == IDX_W'(NUM_REQ-1)) ? '0 : hit + 1'b1;
          timer_d    = '0;
          lock_d     = LOCK_EN & (lock_q | ~req_last[hit]);
          last_d     = req_last[hit];
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_DONE;
        else if (timer_q == 16'(ACK_TIMEOUT-1)) begin
          terr_d  = 1'b1;
          lock_d  = 1'b0;
          state_d = IDLE;
        end else timer_d = timer_q + 16'd1;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
          if (last_q) lock_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      owner       <= '0;
      rr_q        <= '0;
      lock_q      <= 1'b0;
      last_q      <= 1'b0;
      timer_q     <= '0;
      timeout_err <= 1'b0;
      arb_busy    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt         <= gnt_d;
      tx_start    <= start_d;
      tx_data     <= data_d;
      owner       <= owner_d;
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
      timeout_err <= terr_d;
      arb_busy    <= (state_d != IDLE);
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 4-requester DUT plus a 3-requester DUT for pointer wrap.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic stuck = 1'b0;

  logic [3:0]      req = '0, req_last = '0, gnt;
  logic [3:0][7:0] req_data = '0;
  logic            tx_start, tx_busy, arb_busy, timeout_err;
  logic [7:0]      tx_data;
  logic [1:0]      owner;

  logic [2:0]      req3 = '0, req_last3 = '0, gnt3;
  logic [2:0][7:0] req_data3 = '0;
  logic            tx_start3, tx_busy3, arb_busy3, timeout_err3;
  logic [7:0]      tx_data3;
  logic [1:0]      owner3;

  int n_chk = 0, n_fail = 0;

  always #10 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .IDX_W(2), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .arb_busy(arb_busy), .owner(owner), .timeout_err(timeout_err)
  );

  uart_tx_arbiter #(.NUM_REQ(3), .IDX_W(2), .ACK_TIMEOUT(16)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_data(req_data3), .req_last(req_last3),
    .gnt(gnt3), .tx_start(tx_start3), .tx_data(tx_data3), .tx_busy(tx_busy3),
    .arb_busy(arb_busy3), .owner(owner3), .timeout_err(timeout_err3)
  );

  // Transmitter models: busy rises 2 cycles after tx_start and stays high 10 cycles.
  logic [1:0] m_start, m_busy;
  int         m_cnt [2];
  assign m_start  = {tx_start3, tx_start};
  assign tx_busy  = m_busy[0];
  assign tx_busy3 = m_busy[1];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy   <= '0;
      m_cnt[0] <= 0;
      m_cnt[1] <= 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (m_start[c] && !(c == 0 && stuck)) m_cnt[c] <= 1;
        else if (m_cnt[c] != 0) begin
          m_cnt[c] <= m_cnt[c] + 1;
          if (m_cnt[c] == 1) m_busy[c] <= 1'b1;
          if (m_cnt[c] == 11) begin
            m_busy[c] <= 1'b0;
            m_cnt[c]  <= 0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] g);
    case (g)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic wait_grant(input bit sel, input int budget, output logic [3:0] g);
    g = '0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      g = sel ? {1'b0, gnt3} : gnt;
      if (g != '0) return;
    end
  endtask

  task automatic wait_sig(input bit which, input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if ((which ? arb_busy : tx_busy) === lvl) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    bit         ok;
    int         first, cnt0, zeros;
    int         exp_ord [4];

    // Reset state
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_arb_busy", arb_busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_timeout", timeout_err, 0);
    reset = 1'b0;

    // Single requester, one-cycle latency
    @(negedge clk);
    req_data[1] = 8'h55;
    req = 4'b0010;
    wait_grant(0, 1, g);
    chk("single_gnt", g, 4'b0010);
    chk("single_start", tx_start, 1);
    chk("single_data", tx_data, 8'h55);
    chk("single_owner", owner, 1);
    chk("single_busy", arb_busy, 1);
    req = '0;
    @(negedge clk);
    chk("single_gnt_pulse", gnt, 0);
    chk("single_start_pulse", tx_start, 0);
    wait_sig(0, 1'b1, 10, ok);
    chk("single_txbusy_rise", ok, 1);
    wait_sig(0, 1'b0, 20, ok);
    chk("single_txbusy_fall", ok, 1);
    chk("single_arb_still_busy", arb_busy, 1);
    @(negedge clk);
    chk("single_arb_idle", arb_busy, 0);

    // All four requesting continuously
    pulse_reset();
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req = 4'hF;
    for (int i = 0; i < 5; i++) begin
      wait_grant(0, 40, g);
      chk("rr_idx", idx_of(g), i % 4);
      chk("rr_data", tx_data, 8'hA0 + (i % 4));
    end
    req = '0;
    wait_sig(1, 1'b0, 40, ok);
    chk("rr_idle", ok, 1);

    // Reset in WAIT_DONE, then pointer restarts at 0
    req_data[1] = 8'h77;
    req = 4'b0010;
    wait_grant(0, 40, g);
    chk("mid_gnt", g, 4'b0010);
    req = '0;
    wait_sig(0, 1'b1, 10, ok);
    chk("mid_txbusy", ok, 1);
    @(negedge clk);
    req_data[0] = 8'h10;
    req_data[2] = 8'h12;
    req = 4'b0101;
    reset = 1'b1;
    #1;
    chk("async_arb_busy", arb_busy, 0);
    chk("async_owner", owner, 0);
    chk("async_tx_data", tx_data, 0);
    chk("async_gnt", gnt, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_grant(0, 1, g);
    chk("post_rst_gnt", g, 4'b0001);
    req = 4'b0100;
    wait_grant(0, 40, g);
    chk("post_rst_gnt2", g, 4'b0100);
    chk("post_rst_data2", tx_data, 8'h12);
    req = '0;
    wait_sig(1, 1'b0, 40, ok);
    chk("post_rst_idle", ok, 1);

    // Stuck transmitter: timeout exactly 16 cycles after tx_start
    stuck = 1'b1;
    req_data[3] = 8'h3C;
    req = 4'b1000;
    wait_grant(0, 40, g);
    chk("to_gnt", g, 4'b1000);
    first = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (timeout_err && first == 0) first = n;
    end
    chk("to_cycle", first, 16);
    chk("to_idle", arb_busy, 0);
    stuck = 1'b0;
    @(negedge clk);
    chk("to_pulse", timeout_err, 0);
    chk("to_regrant", gnt, 4'b1000);
    req = '0;
    wait_sig(1, 1'b0, 40, ok);
    chk("to_final_idle", ok, 1);

    // Message of three bytes from req0 while req1 waits
`ifdef UART_ARB_LOCK_EN
    exp_ord = '{0, 0, 0, 1};
`else
    exp_ord = '{0, 1, 0, 0};
`endif
    pulse_reset();
    req_data[0] = 8'hB0;
    req_last[0] = 1'b0;
    req_data[1] = 8'hC1;
    req_last[1] = 1'b1;
    req = 4'b0011;
    cnt0 = 0;
    zeros = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(0, 40, g);
      chk("msg_order", idx_of(g), exp_ord[k]);
      chk("msg_data", tx_data, (exp_ord[k] == 0) ? 8'hB0 + zeros : 8'hC1);
      if (exp_ord[k] == 0) zeros++;
      if (g[0]) begin
        cnt0++;
        req_data[0] = 8'hB0 + 8'(cnt0);
        req_last[0] = (cnt0 == 2);
        if (cnt0 == 3) req[0] = 1'b0;
      end
      if (g[1]) req[1] = 1'b0;
    end
    req = '0;
    req_last = '0;

    // NUM_REQ=3 pointer wrap: 0,2,0,2
    req_data3 = {8'hD2, 8'hD1, 8'hD0};
    req3 = 3'b101;
    for (int k = 0; k < 4; k++) begin
      wait_grant(1, 40, g);
      chk("wrap_idx", idx_of(g), (k % 2) * 2);
      chk("wrap_owner", owner3, (k % 2) * 2);
      chk("wrap_data", tx_data3, 8'hD0 + (k % 2) * 2);
    end
    req3 = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
